// File: rtl/hex_seg_capture.sv
// hex_seg_capture: debounces 7-segment pins and digit strobes and assembles 4-digit hex frames.
// Define HEX_SEG_CHANGE_ONLY_EN to drop completed frames that repeat the last delivered one.
module hex_seg_capture #(
    parameter int STABLE_CYC = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [6:0]  SEG,
    input  logic [3:0]  DIG_SEL,
    input  logic        ACK,
    output logic [15:0] DIGITS,
    output logic        VALID,
    output logic        OVR,
    output logic        ERR
);
    typedef enum logic {SETTLE, CAPTURED} state_t;
    localparam logic [7:0] LAST = 8'(STABLE_CYC - 1);

    state_t      state_q;
    logic [6:0]  seg_s1_q, seg_s2_q;
    logic [3:0]  sel_s1_q, sel_s2_q;
    logic [7:0]  cnt_q;
    logic [3:0]  slot_q [4];
    logic [3:0]  seen_q, seen_d;
    logic [15:0] digits_q, frame;
    logic        valid_q, ovr_q, err_q;
`ifdef HEX_SEG_CHANGE_ONLY_EN
    logic        shown_q;
`endif
    logic        stable, capture, frame_done, deliver, frame_err;
    logic [1:0]  idx;
    logic [3:0]  code;

    function automatic logic [3:0] decode(input logic [6:0] l);
        case (l)
            7'h3F:   decode = 4'h0;
            7'h06:   decode = 4'h1;
            7'h5B:   decode = 4'h2;
            7'h4F:   decode = 4'h3;
            7'h66:   decode = 4'h4;
            7'h6D:   decode = 4'h5;
            7'h7C:   decode = 4'h6;
            7'h07:   decode = 4'h7;
            7'h7F:   decode = 4'h8;
            7'h6F:   decode = 4'h9;
            7'h40:   decode = 4'hA;
            7'h00:   decode = 4'hB;
            default: decode = 4'hF;
        endcase
    endfunction

    // Stability compares the value about to enter stage 2 with stage 2 itself,
    // so a window closes one edge earlier than a separate history register would.
    always_comb begin
        stable     = seg_s1_q == seg_s2_q && sel_s1_q == sel_s2_q && $onehot(~sel_s2_q);
        capture    = state_q == SETTLE && stable && cnt_q == LAST;
        idx        = !sel_s2_q[0] ? 2'd0 : !sel_s2_q[1] ? 2'd1 : !sel_s2_q[2] ? 2'd2 : 2'd3;
        code       = decode(~seg_s2_q);
        frame      = {slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
        frame_err  = slot_q[0] == 4'hF || slot_q[1] == 4'hF || slot_q[2] == 4'hF || slot_q[3] == 4'hF;
        frame_done = seen_q == 4'hF;
`ifdef HEX_SEG_CHANGE_ONLY_EN
        deliver    = frame_done && !(shown_q && frame == digits_q);
`else
        deliver    = frame_done;
`endif
        seen_d     = (frame_done ? 4'h0 : seen_q) | (capture ? 4'b0001 << idx : 4'h0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= SETTLE;
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            sel_s1_q <= '0;
            sel_s2_q <= '0;
            cnt_q    <= '0;
            slot_q   <= '{default: 4'h0};
            seen_q   <= '0;
            digits_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef HEX_SEG_CHANGE_ONLY_EN
            shown_q  <= 1'b0;
`endif
        end else begin
            seg_s1_q <= SEG;
            seg_s2_q <= seg_s1_q;
            sel_s1_q <= DIG_SEL;
            sel_s2_q <= sel_s1_q;
            seen_q   <= seen_d;
            case (state_q)
                SETTLE: begin
                    cnt_q <= stable && !capture ? cnt_q + 8'd1 : 8'd0;
                    if (capture) begin
                        slot_q[idx] <= code;
                        state_q     <= CAPTURED;
                    end
                end
                CAPTURED: if (sel_s1_q != sel_s2_q) state_q <= SETTLE;
            endcase
            if (deliver) begin
                digits_q <= frame;
                valid_q  <= 1'b1;
                ovr_q    <= !ACK && (ovr_q || valid_q);
                err_q    <= frame_err;
`ifdef HEX_SEG_CHANGE_ONLY_EN
                shown_q  <= 1'b1;
`endif
            end else if (ACK && valid_q) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
        end
    end

    assign DIGITS = digits_q;
    assign VALID  = valid_q;
    assign OVR    = ovr_q;
    assign ERR    = err_q;
endmodule

// File: tb/tb_hex_seg_capture.sv
// tb_hex_seg_capture: directed and randomized stimulus checked every cycle against
// a frame-level reference model; literal expectations pin both DUT and model.
module tb_hex_seg_capture;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  dig_sel = 4'hF;
    logic        ack = 1'b0;
    logic [15:0] DIGITS;
    logic        VALID, OVR, ERR;
    int          checks = 0;
    int          errors = 0;

    hex_seg_capture #(.STABLE_CYC(SC)) dut (
        .CLK(clk), .RST(rst), .SEG(seg), .DIG_SEL(dig_sel), .ACK(ack),
        .DIGITS(DIGITS), .VALID(VALID), .OVR(OVR), .ERR(ERR)
    );

    always #5 clk = ~clk;

    // lit-segment pattern for each code 0..B, position == code
    logic [6:0] l_tab [12] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                               7'h7C, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h00};

    function automatic logic [3:0] m_dec(input logic [6:0] l);
        for (int i = 0; i < 12; i++) if (l_tab[i] == l) return 4'(i);
        return 4'hF;
    endfunction

    // model: h1/h2 are the pin values applied one and two edges ago
    logic [10:0] h1, h2;
    int          run;
    bit          capt, go, m_valid, m_ovr, m_err, m_shown;
    logic [3:0]  m_slot [4];
    logic [3:0]  m_seen;
    logic [15:0] m_dig;

    always @(posedge clk) begin : model
        logic [15:0] fr;
        bit st, cap, dlv;
        int ix;
        if (rst) begin
            go = 1; h1 = '0; h2 = '0; run = 0; capt = 0; m_seen = '0; m_dig = '0;
            m_valid = 0; m_ovr = 0; m_err = 0; m_shown = 0;
            for (int i = 0; i < 4; i++) m_slot[i] = '0;
        end else begin
            st = (h1 == h2) && ($countones(~h2[10:7]) == 1);
            cap = 0;
            if (capt) begin
                if (h1[10:7] != h2[10:7]) capt = 0;
                run = 0;
            end else begin
                run = st ? run + 1 : 0;
                if (run == SC) begin cap = 1; capt = 1; end
            end
            dlv = 0;
            if (m_seen == 4'hF) begin
                fr = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
                dlv = 1;
`ifdef HEX_SEG_CHANGE_ONLY_EN
                if (m_shown && fr == m_dig) dlv = 0;
`endif
                if (dlv) begin
                    m_ovr = ack ? 0 : (m_ovr | m_valid);
                    m_valid = 1; m_dig = fr; m_shown = 1;
                    m_err = (fr[3:0] == 4'hF) || (fr[7:4] == 4'hF) || (fr[11:8] == 4'hF) || (fr[15:12] == 4'hF);
                end
                m_seen = '0;
            end
            if (!dlv && ack && m_valid) begin m_valid = 0; m_ovr = 0; end
            if (cap) begin
                ix = 0;
                for (int i = 3; i >= 0; i--) if (!h2[7+i]) ix = i;
                m_slot[ix] = m_dec(~h2[6:0]);
                m_seen[ix] = 1'b1;
            end
            h2 = h1;
            h1 = {dig_sel, seg};
        end
    end

    task automatic tick();
        @(negedge clk);
        if (go) begin
            checks++;
            if ({DIGITS, VALID, OVR, ERR} !== {m_dig, m_valid, m_ovr, m_err}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got dig=%h v=%b o=%b e=%b expected dig=%h v=%b o=%b e=%b",
                         $time, DIGITS, VALID, OVR, ERR, m_dig, m_valid, m_ovr, m_err);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic show(input int d, input logic [6:0] l, input int n);
        seg = ~l;
        dig_sel = ~(4'b0001 << d);
        repeat (n) tick();
    endtask

    task automatic frame(input logic [15:0] v, input int n);
        for (int d = 0; d < 4; d++) show(d, l_tab[v[4*d +: 4]], n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_digits", DIGITS, 0);
        chk("reset_flags", {VALID, OVR, ERR}, 0);
        // 4321 frame with exact latency on the last digit
        show(0, 7'h06, 10);
        show(1, 7'h5B, 10);
        show(2, 7'h4F, 10);
        seg = ~7'h66;
        dig_sel = 4'b0111;
        repeat (6) tick();
        chk("latency_pre", VALID, 0);
        tick();
        chk("latency_valid", VALID, 1);
        repeat (3) tick();
        chk("f4321_digits", DIGITS, 16'h4321);
        chk("f4321_model", m_dig, 16'h4321);
        chk("f4321_err", ERR, 0);
        ack_pulse();
        chk("ack_clears", VALID, 0);
        // minus, blank and illegal pattern
        show(0, 7'h00, 10);
        show(1, 7'h06, 10);
        show(2, 7'h40, 10);
        show(3, 7'h01, 10);
        chk("special_digits", DIGITS, 16'hFA1B);
        chk("special_model", m_dig, 16'hFA1B);
        chk("special_err", ERR, 1);
        ack_pulse();
        chk("err_sticky", {VALID, ERR}, 2'b01);
        // digit 1 held too briefly: frame never completes
        show(1, 7'h5B, 3);
        dig_sel = 4'hF;
        repeat (5) tick();
        show(0, 7'h06, 10);
        show(2, 7'h4F, 10);
        show(3, 7'h66, 10);
        chk("short_hold", VALID, 0);
        // overrun then acknowledge
        do_reset();
        frame(16'h1111, 10);
        frame(16'h2222, 10);
        chk("ovr_digits", DIGITS, 16'h2222);
        chk("ovr_flags", {VALID, OVR}, 2'b11);
        ack_pulse();
        chk("ovr_ack", {VALID, OVR}, 2'b00);
        // invalid strobe, reset with partial frame
        frame(16'h7B80, 10);
        show(0, 7'h3F, 10);
        show(1, 7'h06, 10);
        show(2, 7'h5B, 10);
        dig_sel = 4'b1100;
        repeat (20) tick();
        chk("multi_strobe", {DIGITS, VALID}, {16'h7B80, 1'b1});
        do_reset();
        chk("mid_reset", {DIGITS, VALID, OVR, ERR}, 0);
        show(1, 7'h06, 10);
        show(2, 7'h06, 10);
        show(3, 7'h06, 10);
        chk("partial_after_reset", VALID, 0);
        show(0, 7'h06, 10);
        chk("full_after_reset", {DIGITS, VALID}, {16'h1111, 1'b1});
        ack_pulse();
`ifdef HEX_SEG_CHANGE_ONLY_EN
        do_reset();
        frame(16'h9876, 10);
        chk("dup_first", {DIGITS, VALID}, {16'h9876, 1'b1});
        ack_pulse();
        frame(16'h9876, 10);
        chk("dup_dropped", VALID, 0);
        chk("dup_model", m_valid, 0);
`endif
        // randomized patterns
        for (int it = 0; it < 400; it++) begin
            int n;
            if ($urandom_range(0, 99) == 0) do_reset();
            dig_sel = ($urandom_range(0, 99) < 85) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            seg = ($urandom_range(0, 99) < 80) ? ~l_tab[$urandom_range(0, 11)] : 7'($urandom);
            n = $urandom_range(1, 12);
            repeat (n) begin
                ack = ($urandom_range(0, 5) == 0);
                tick();
            end
            ack = 1'b0;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_seg_capture.md
HEX_SEG_CAPTURE -- requirements
Module: hex_seg_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4, SHALL set the consecutive synchronized cycles a digit's pins must hold before capture; legal range 1..255.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 SEG  input  7  active-low segment pins: bit0 H0 (top), bit1 V1 (upper right), bit2 V3 (lower right), bit3 H2 (bottom), bit4 V2 (lower left), bit5 V0 (upper left), bit6 H1 (middle).
REQ-005 DIG_SEL  input  4  active-low digit strobes; bit n low selects digit n.
REQ-006 DIGITS  output  16  captured frame; nibble n = digit n code.
REQ-007 VALID  output  1  frame available in DIGITS.
REQ-008 ACK  input  1  consumer acknowledge.
REQ-009 OVR  output  1  sticky overrun: a frame replaced an unacknowledged frame.
REQ-010 ERR  output  1  sticky: some digit in the current DIGITS decoded to 4'hF.

Function
REQ-011 SEG and DIG_SEL SHALL each pass a 2-flop synchronizer; all further logic uses synchronized values.
REQ-012 Decoding SHALL use L = ~SEG. Codes: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7C->6, 0x07->7, 0x7F->8, 0x6F->9, 0x40->4'hA (minus), 0x00->4'hB (blank); any other L->4'hF.
REQ-013 Strobe valid only when exactly one DIG_SEL bit is low; zero or several low SHALL clear the stability counter and block capture.
REQ-014 Capture FSM states: SETTLE, CAPTURED.
REQ-015 SETTLE: 8-bit counter increments each cycle while synchronized SEG and DIG_SEL equal their previous-cycle values and strobe valid; any change or invalid strobe SHALL reload counter to 0.
REQ-016 When counter reaches STABLE_CYC-1 and inputs still stable, that edge SHALL write the decoded code into internal digit slot n, set seen[n], enter CAPTURED.
REQ-017 CAPTURED: no further capture; any change of synchronized DIG_SEL SHALL return to SETTLE with counter 0; SEG changes alone ignored.
REQ-018 When seen = 4'b1111, the next edge SHALL copy all slots to DIGITS, set VALID, recompute ERR from new DIGITS, clear seen.
REQ-019 VALID SHALL hold until an edge with ACK=1 and no frame completing; that edge clears VALID and OVR; ACK with VALID=0 has no effect.
REQ-020 Frame completion with VALID=1 and ACK=0: DIGITS overwritten, VALID stays 1, OVR set.
REQ-021 Frame completion with ACK=1 same cycle: new frame latched, VALID stays 1, OVR cleared.
REQ-022 Recapturing a digit already in seen SHALL overwrite its slot; frame completes only when all four bits set.
REQ-023 Latency: final digit stable at pins -> VALID high after 2+STABLE_CYC+1 edges.

Reset
REQ-024 RST=1 at an edge SHALL clear synchronizers, counter, slots, seen, DIGITS=16'h0000, VALID=0, OVR=0, ERR=0, FSM=SETTLE, regardless of state, including mid-settle or with VALID pending.
REQ-025 First capture after reset release SHALL require a full STABLE_CYC stability window.

Configuration
REQ-026 Macro HEX_SEG_CHANGE_ONLY_EN defined: completed frame equal to the last delivered DIGITS SHALL be discarded (no VALID, OVR, ERR update, seen cleared); first frame after reset always delivered.
REQ-027 Macro undefined: every completed frame delivered per REQ-018..021.

Verification
REQ-028 STABLE_CYC=4, digits 0..3 show L=0x06,0x5B,0x4F,0x66 for 10 cycles each -> DIGITS=16'h4321, VALID=1, ERR=0.
REQ-029 Digit 2 shows L=0x40, digit 0 L=0x00, digit 3 L=0x01 -> nibbles A, B, F; ERR=1.
REQ-030 Digit 1 held only 3 stable cycles with STABLE_CYC=4, then strobe moves -> no capture, VALID stays 0.
REQ-031 Two frames 16'h1111 then 16'h2222, no ACK -> DIGITS=16'h2222, VALID=1, OVR=1; ACK pulse -> VALID=0, OVR=0.
REQ-032 DIG_SEL=4'b1100 for 20 cycles -> no capture; RST asserted with seen=4'b0111 -> all outputs zero, next frame needs all four digits.
REQ-033 HEX_SEG_CHANGE_ONLY_EN defined, identical frame 16'h9876 twice with ACK between -> VALID asserts once only.
